disp_pixel_fifo: RTL and testbench

- Clock-domain-crossing pixel buffer directly downstream of the VRAM read controller.
- Captures every AXI read-data beat in the ACLK domain and drives FIFO_READY back to the controller as burst flow control.
- Delivers one 24-bit RGB pixel per pixel-clock cycle to the VGA timing/output stage in the DCLK domain.
- Asynchronous dual-clock FIFO: Gray-coded pointers, 2-FF pointer synchronizers, sticky error flags.

---
 rtl/disp_pixel_fifo.sv | 152 +++++++++++++++
 tb/tb_disp_pixel_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_pixel_fifo.sv
// rtl/disp_pixel_fifo.sv - dual-clock pixel FIFO from AXI read data (ACLK) to the VGA pixel stream (DCLK)
`timescale 1ns/1ps
module disp_pixel_fifo #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int READY_THRESH = 64
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    input  logic                  RREADY,
    output logic                  FIFO_READY,
    output logic                  OVERFLOW,
    input  logic                  DCLK,
    input  logic                  RD_EN,
    output logic [7:0]            DOUT_R,
    output logic [7:0]            DOUT_G,
    output logic [7:0]            DOUT_B,
    output logic                  UNDERFLOW
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PIX_W = 24;

    localparam logic [PW:0] DEPTH_W  = DEPTH[PW:0];
    localparam logic [PW:0] THRESH_W = READY_THRESH[PW:0];

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Only the pixel bytes are kept; the pad byte of each beat is discarded.
    logic [PIX_W-1:0] mem [DEPTH];
    logic             unused_rdata_hi;
    assign unused_rdata_hi = ^RDATA[DATA_WIDTH-1:PIX_W];

    // ---------------- write side (ACLK) ----------------
    logic [PW-1:0] wr_bin_q, wr_bin_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_gray_s1_q, rd_gray_s2_q;
    logic          fifo_ready_q, fifo_ready_d;
    logic          overflow_q;
    logic [PW-1:0] wr_count;
    logic [PW:0]   free_words;
    logic          wr_req, wr_en, full;

    // Gray pointer from the read side is rebuilt to binary here, so free space lags true space (never overstates).
    always_comb begin
        wr_req       = RVALID & RREADY;
        full         = (wr_gray_q == {~rd_gray_s2_q[PW-1:PW-2], rd_gray_s2_q[PW-3:0]});
        wr_en        = wr_req & ~full;
        wr_bin_d     = wr_bin_q + {{(PW-1){1'b0}}, wr_en};
        wr_gray_d    = bin2gray(wr_bin_d);
        wr_count     = wr_bin_q - gray2bin(rd_gray_s2_q);
        free_words   = DEPTH_W - {1'b0, wr_count};
        fifo_ready_d = (free_words >= THRESH_W);
    end

    // Pixel storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ACLK) begin
        if (wr_en && !ARST) begin
            mem[wr_bin_q[ADDR_WIDTH-1:0]] <= RDATA[PIX_W-1:0];
        end
    end

    // Write pointer, read-pointer synchronizer, flow control and sticky overflow.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wr_bin_q     <= '0;
            wr_gray_q    <= '0;
            rd_gray_s1_q <= '0;
            rd_gray_s2_q <= '0;
            fifo_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_bin_q     <= wr_bin_d;
            wr_gray_q    <= wr_gray_d;
            rd_gray_s1_q <= rd_gray_q;
            rd_gray_s2_q <= rd_gray_s1_q;
            fifo_ready_q <= fifo_ready_d;
            if (wr_req && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign FIFO_READY = fifo_ready_q;
    assign OVERFLOW   = overflow_q;

    // ---------------- read side (DCLK) ----------------
    logic          drst_s1_q, drst_s2_q;
    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] wr_gray_s1_q, wr_gray_s2_q;
    logic [PIX_W-1:0] dout_q;
    logic          underflow_q;
    logic          empty, rd_en_ok;

    // Bring ARST into the pixel domain; it must be held long enough for this chain to see it.
    always_ff @(posedge DCLK) begin
        drst_s1_q <= ARST;
        drst_s2_q <= drst_s1_q;
    end

    always_comb begin
        empty     = (rd_gray_q == wr_gray_s2_q);
        rd_en_ok  = RD_EN & ~empty;
        rd_bin_d  = rd_bin_q + {{(PW-1){1'b0}}, rd_en_ok};
        rd_gray_d = bin2gray(rd_bin_d);
    end

    // Read pointer, write-pointer synchronizer, pixel output (black unless a pixel is popped), sticky underflow.
    always_ff @(posedge DCLK) begin
        if (drst_s2_q) begin
            rd_bin_q     <= '0;
            rd_gray_q    <= '0;
            wr_gray_s1_q <= '0;
            wr_gray_s2_q <= '0;
            dout_q       <= '0;
            underflow_q  <= 1'b0;
        end else begin
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= rd_gray_d;
            wr_gray_s1_q <= wr_gray_q;
            wr_gray_s2_q <= wr_gray_s1_q;
            if (rd_en_ok) begin
                dout_q <= mem[rd_bin_q[ADDR_WIDTH-1:0]];
            end else begin
                dout_q <= '0;
            end
            if (RD_EN && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign DOUT_R    = dout_q[23:16];
    assign DOUT_G    = dout_q[15:8];
    assign DOUT_B    = dout_q[7:0];
    assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_disp_pixel_fifo.sv
// tb/tb_disp_pixel_fifo.sv - randomized self-checking bench for disp_pixel_fifo against a queue model
`timescale 1ns/1ps
module tb_disp_pixel_fifo;
    localparam int  DEPTH  = 512;
    localparam int  THRESH = 64;
    localparam time AGE    = 160;

    logic        ACLK = 1'b0;
    logic        DCLK = 1'b0;
    logic        ARST = 1'b1;
    logic [31:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RREADY = 1'b0;
    logic        FIFO_READY, OVERFLOW, UNDERFLOW;
    logic        RD_EN = 1'b0;
    logic [7:0]  DOUT_R, DOUT_G, DOUT_B;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    time         t_q[$];
    bit          exp_ovf = 1'b0;
    bit          exp_unf = 1'b0;
    int          rd_mode = 0;
    int          rd_budget = 0;
    bit          pend = 1'b0;
    logic [23:0] pend_exp = '0;
    bit          rd_live = 1'b0;

    disp_pixel_fifo dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .FIFO_READY (FIFO_READY),
        .OVERFLOW   (OVERFLOW),
        .DCLK       (DCLK),
        .RD_EN      (RD_EN),
        .DOUT_R     (DOUT_R),
        .DOUT_G     (DOUT_G),
        .DOUT_B     (DOUT_B),
        .UNDERFLOW  (UNDERFLOW)
    );

    always #5 ACLK = ~ACLK;
    initial begin
        #3;
        forever #20 DCLK = ~DCLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reader: checks last cycle's pixel, then decides this cycle's RD_EN from the model.
    initial begin
        logic [31:0] w;
        time         tt;
        bit          rd;
        forever begin
            @(negedge DCLK);
            if (rd_live) begin
                check_val("dout", {8'h00, DOUT_R, DOUT_G, DOUT_B}, pend ? {8'h00, pend_exp} : 32'h0);
            end
            pend = 1'b0;
            rd   = 1'b0;
            if (rd_mode == 2 && rd_budget > 0) begin
                rd = 1'b1;
                rd_budget--;
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    tt = t_q.pop_front();
                    pend = 1'b1;
                    pend_exp = w[23:0];
                end else begin
                    exp_unf = 1'b1;
                end
            end else if (rd_mode == 1 && exp_q.size() > 0 && ($time - t_q[0]) >= AGE
                         && $urandom_range(0, 99) < 60) begin
                rd = 1'b1;
                w = exp_q.pop_front();
                tt = t_q.pop_front();
                pend = 1'b1;
                pend_exp = w[23:0];
            end
            RD_EN = rd;
        end
    end

    task automatic push_model(input logic [31:0] d);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
            t_q.push_back($time);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        @(negedge ACLK);
        RDATA = d;
        RVALID = 1'b1;
        RREADY = 1'b1;
        @(posedge ACLK);
        push_model(d);
    endtask

    task automatic idle_bus();
        @(negedge ACLK);
        RVALID = 1'b0;
        RREADY = 1'b0;
    endtask

    task automatic read_n(input int n);
        int guard;
        guard = 0;
        rd_budget = n;
        rd_mode = 2;
        while ((rd_budget > 0 || pend) && guard < n * 8 + 64) begin
            @(posedge ACLK);
            guard++;
        end
        if (rd_budget > 0 || pend) check_val("read_timeout", 32'd1, 32'd0);
        rd_mode = 0;
        rd_budget = 0;
        @(negedge DCLK);
        @(negedge DCLK);
    endtask

    task automatic do_reset(input int n_dclk);
        rd_mode = 0;
        rd_budget = 0;
        @(negedge ACLK);
        RVALID = 1'b0;
        RREADY = 1'b0;
        ARST = 1'b1;
        exp_q.delete();
        t_q.delete();
        repeat (2) @(posedge ACLK);
        #1;
        check_val("rst_fifo_ready", {31'd0, FIFO_READY}, 32'd0);
        check_val("rst_overflow", {31'd0, OVERFLOW}, 32'd0);
        repeat (n_dclk * 4 - 2) @(posedge ACLK);
        #1;
        check_val("rst_underflow", {31'd0, UNDERFLOW}, 32'd0);
        check_val("rst_dout", {8'h00, DOUT_R, DOUT_G, DOUT_B}, 32'd0);
        @(negedge ACLK);
        ARST = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(posedge ACLK);
        #1;
        check_val("rst_ready_after", {31'd0, FIFO_READY}, 32'd1);
        repeat (4) @(negedge DCLK);
        rd_live = 1'b1;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_w;
        int guard;
        bit v;

        // Basic ordered transfer of 32 pixels
        do_reset(5);
        for (int i = 0; i < 32; i++) write_word(32'h00FF8040 + i);
        idle_bus();
        #200;
        read_n(32);
        check_val("basic_underflow", {31'd0, UNDERFLOW}, 32'd0);
        check_val("basic_overflow", {31'd0, OVERFLOW}, 32'd0);

        // Read while empty, then recover with fresh data
        read_n(1);
        check_val("unf_set", {31'd0, UNDERFLOW}, {31'd0, exp_unf});
        write_word(32'h00ABCDEF);
        idle_bus();
        #200;
        read_n(1);
        check_val("unf_sticky", {31'd0, UNDERFLOW}, 32'd1);

        // FIFO_READY threshold while filling with no reads
        do_reset(5);
        for (int k = 1; k <= 449; k++) begin
            write_word(32'h00A00000 + k);
            #1;
            check_val("fill_ready", {31'd0, FIFO_READY}, {31'd0, (DEPTH - (k - 1)) >= THRESH});
        end
        idle_bus();
        @(posedge ACLK);
        #1;
        check_val("ready_drop", {31'd0, FIFO_READY}, 32'd0);
        read_n(1);
        repeat (4) @(posedge ACLK);
        #1;
        check_val("ready_return", {31'd0, FIFO_READY}, 32'd1);

        // Overflow: 513 writes, 512 kept
        do_reset(5);
        for (int k = 0; k < 513; k++) write_word($urandom);
        idle_bus();
        @(posedge ACLK);
        #1;
        check_val("ovf_set", {31'd0, OVERFLOW}, {31'd0, exp_ovf});
        check_val("ovf_ready", {31'd0, FIFO_READY}, 32'd0);
        #200;
        read_n(512);
        check_val("ovf_sticky", {31'd0, OVERFLOW}, 32'd1);
        check_val("ovf_no_unf", {31'd0, UNDERFLOW}, 32'd0);

        // Streaming with wrap-around and random read duty
        do_reset(5);
        rd_mode = 1;
        n_w = 0;
        guard = 0;
        while (n_w < 2000 && guard < 60000) begin
            @(negedge ACLK);
            guard++;
            v = ($urandom_range(0, 3) != 0) && FIFO_READY;
            RVALID = v;
            RREADY = ($urandom_range(0, 7) != 0);
            RDATA = $urandom;
            @(posedge ACLK);
            if (RVALID && RREADY) begin
                push_model(RDATA);
                n_w++;
            end
        end
        idle_bus();
        while (exp_q.size() > 0 && guard < 80000) begin
            @(posedge ACLK);
            guard++;
        end
        check_val("stream_written", n_w, 32'd2000);
        check_val("stream_drained", exp_q.size(), 32'd0);
        rd_mode = 0;
        repeat (2) @(negedge DCLK);
        check_val("stream_overflow", {31'd0, OVERFLOW}, 32'd0);
        check_val("stream_underflow", {31'd0, UNDERFLOW}, 32'd0);

        // Reset with 100 words buffered discards everything
        for (int k = 0; k < 100; k++) write_word($urandom);
        idle_bus();
        #300;
        do_reset(5);
        check_val("mid_rst_overflow", {31'd0, OVERFLOW}, 32'd0);
        check_val("mid_rst_underflow", {31'd0, UNDERFLOW}, 32'd0);
        write_word(32'h00123456);
        idle_bus();
        #200;
        read_n(1);
        check_val("mid_rst_first_unf", {31'd0, UNDERFLOW}, 32'd0);
        read_n(1);
        check_val("mid_rst_empty", {31'd0, UNDERFLOW}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
